// File: rtl/pc_fetch_unit_if.sv
// Bundle of redirect, instruction-memory and decode-side handshakes for the fetch unit.
// The fetch unit takes the master view; the surrounding pipeline/memory takes the slave view.
interface pc_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_err;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_err
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, fetch_err
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// In-order instruction fetch: owns the fetch PC, tags in-flight requests, drops stale
// responses after a redirect and presents {pc, instr} to decode from a small registered queue.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned QDEPTH   = 2
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.master bus
);
  localparam int unsigned PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW  = $clog2(QDEPTH + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(QDEPTH - 1);
  localparam logic [CW:0]   QDEPTH_W = CW1'(QDEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1'b1);
    end
  endfunction

  state_t        state_r;
  logic          err_r;
  logic [31:0]   pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;
  logic [31:0]   tag_r [QDEPTH];
  logic [PW-1:0] tag_rd_r;
  logic [PW-1:0] tag_wr_r;
  logic [31:0]   q_pc_r [QDEPTH];
  logic [31:0]   q_instr_r [QDEPTH];
  logic [PW-1:0] q_rd_r;
  logic [PW-1:0] q_wr_r;
  logic [CW-1:0] qcount_r;

  logic          redir_ok_s;
  logic          redir_bad_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_s;
  logic          rsp_drop_s;
  logic          rsp_keep_s;
  logic          pop_s;
  logic [CW:0]   occupancy_s;
  logic [CW-1:0] inflight_next_s;

  // Every issued request reserves a queue slot, so in-flight plus queued never exceeds QDEPTH.
  assign occupancy_s     = {1'b0, inflight_r} + {1'b0, qcount_r};
  assign redir_ok_s      = (state_r == ST_FETCH) && bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
  assign redir_bad_s     = (state_r == ST_FETCH) && bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign req_valid_s     = (state_r == ST_FETCH) && !bus.redirect_valid && (occupancy_s < QDEPTH_W);
  assign req_fire_s      = req_valid_s && bus.imem_req_ready;
  assign rsp_s           = bus.imem_rsp_valid && (inflight_r != {CW{1'b0}});
  assign rsp_drop_s      = rsp_s && (drop_r != {CW{1'b0}});
  assign rsp_keep_s      = rsp_s && (drop_r == {CW{1'b0}}) && !redir_ok_s;
  assign pop_s           = (qcount_r != {CW{1'b0}}) && bus.if_ready;
  assign inflight_next_s = inflight_r + CW'(req_fire_s) - CW'(rsp_s);

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_r;
  assign bus.if_valid       = (qcount_r != {CW{1'b0}});
  assign bus.if_pc          = q_pc_r[q_rd_r];
  assign bus.if_instr       = q_instr_r[q_rd_r];
  assign bus.fetch_err      = err_r;

  // Control FSM; a misaligned redirect parks the unit in ERR until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_BOOT;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_BOOT: begin
          state_r <= ST_FETCH;
          err_r   <= 1'b0;
        end
        ST_FETCH: begin
          if (redir_bad_s) begin
            state_r <= ST_ERR;
            err_r   <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
            err_r   <= 1'b0;
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
          err_r   <= 1'b1;
        end
        default: begin
          state_r <= ST_ERR;
          err_r   <= 1'b1;
        end
      endcase
    end
  end

  // Fetch PC and outstanding/stale counters; a redirect marks everything still in flight as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      drop_r     <= {CW{1'b0}};
    end else begin
      inflight_r <= inflight_next_s;
      if (redir_ok_s) begin
        pc_r   <= bus.redirect_pc;
        drop_r <= inflight_next_s;
      end else begin
        if (req_fire_s) begin
          pc_r <= pc_r + 32'd4;
        end
        if (rsp_drop_s) begin
          drop_r <= drop_r - CW'(1'b1);
        end
      end
    end
  end

  // Tag FIFO holding the PC of each live (non-stale) in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_rd_r <= {PW{1'b0}};
      tag_wr_r <= {PW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        tag_r[i] <= 32'd0;
      end
    end else if (redir_ok_s) begin
      tag_rd_r <= {PW{1'b0}};
      tag_wr_r <= {PW{1'b0}};
    end else begin
      if (req_fire_s) begin
        tag_r[tag_wr_r] <= pc_r;
        tag_wr_r        <= ptr_inc(tag_wr_r);
      end
      if (rsp_keep_s) begin
        tag_rd_r <= ptr_inc(tag_rd_r);
      end
    end
  end

  // Decode-side queue; entries are registered so decode never sees imem_rsp combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rd_r   <= {PW{1'b0}};
      q_wr_r   <= {PW{1'b0}};
      qcount_r <= {CW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_r[i]    <= 32'd0;
        q_instr_r[i] <= 32'd0;
      end
    end else if (redir_ok_s) begin
      q_rd_r   <= {PW{1'b0}};
      q_wr_r   <= {PW{1'b0}};
      qcount_r <= {CW{1'b0}};
    end else begin
      if (rsp_keep_s) begin
        q_pc_r[q_wr_r]    <= tag_r[tag_rd_r];
        q_instr_r[q_wr_r] <= bus.imem_rsp_data;
        q_wr_r            <= ptr_inc(q_wr_r);
      end
      if (pop_s) begin
        q_rd_r <= ptr_inc(q_rd_r);
      end
      qcount_r <= qcount_r + CW'(rsp_keep_s) - CW'(pop_s);
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: an epoch-based reference model predicts requests and
// the {pc, instr} stream delivered to decode; a simple in-order memory model answers fetches.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_unit_if fbus ();

  pc_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  req_t        mq[$];
  ent_t        dq[$];
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];
  logic [31:0] m_pc;
  int          mode;
  int          epoch;
  int          cyc;
  int          last_due;
  int          p_ready, p_ifready, lat_min, lat_max;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] del_at(input int i);
    return (del_log.size() > i) ? del_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fbus.redirect_valid = 1'b0;
    fbus.redirect_pc    = 32'd0;
    fbus.imem_req_ready = 1'b0;
    fbus.imem_rsp_valid = 1'b0;
    fbus.imem_rsp_data  = 32'd0;
    fbus.if_ready       = 1'b0;
    #1;
    check("rst_req_valid", fbus.imem_req_valid, 32'd0);
    check("rst_req_addr", fbus.imem_req_addr, RESET_PC);
    check("rst_if_valid", fbus.if_valid, 32'd0);
    check("rst_if_pc", fbus.if_pc, 32'd0);
    check("rst_if_instr", fbus.if_instr, 32'd0);
    check("rst_fetch_err", fbus.fetch_err, 32'd0);
    mq.delete(); dq.delete(); acc_log.delete(); del_log.delete();
    epoch    = 0;
    last_due = -1;
    m_pc     = RESET_PC;
    mode     = 1;  // the cycle between release and the next edge is the boot cycle
    #2;
    rst = 1'b0;
  endtask

  task automatic do_cycle(input bit redir, input logic [31:0] raddr);
    bit   rdy, ifr, rspv, exp_req, aligned;
    req_t r;
    int   d;
    @(negedge clk);
    rdy     = ($urandom_range(99) < p_ready);
    ifr     = ($urandom_range(99) < p_ifready);
    rspv    = (mq.size() > 0) && (mq[0].due <= cyc);
    aligned = (raddr[1:0] == 2'b00);
    fbus.redirect_valid = redir;
    fbus.redirect_pc    = redir ? raddr : $urandom;
    fbus.imem_req_ready = rdy;
    fbus.if_ready       = ifr;
    fbus.imem_rsp_valid = rspv;
    fbus.imem_rsp_data  = rspv ? mem_word(mq[0].addr) : $urandom;
    #1;
    exp_req = (mode == 1) && !redir && ((mq.size() + dq.size()) < 2);
    check("req_valid", fbus.imem_req_valid, exp_req);
    check("req_addr", fbus.imem_req_addr, m_pc);
    check("if_valid", fbus.if_valid, dq.size() > 0);
    check("fetch_err", fbus.fetch_err, mode == 2);
    if (dq.size() > 0 && ifr) begin
      check("if_pc", fbus.if_pc, dq[0].pc);
      check("if_instr", fbus.if_instr, dq[0].instr);
      del_log.push_back(dq[0].pc);
      void'(dq.pop_front());
    end
    if (rspv) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !(mode == 1 && redir && aligned))
        dq.push_back('{pc: r.addr, instr: mem_word(r.addr)});
    end
    if (exp_req && rdy) begin
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: m_pc, epoch: epoch, due: d});
      acc_log.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (mode == 1 && redir) begin
      if (aligned) begin
        epoch++;
        dq.delete();
        m_pc = raddr;
      end else begin
        mode = 2;
      end
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  base, n;
    bit  found;
    int  r;
    rst = 1'b1;
    cyc = 0;
    fbus.redirect_valid = 1'b0; fbus.redirect_pc = 32'd0;
    fbus.imem_req_ready = 1'b0; fbus.imem_rsp_valid = 1'b0;
    fbus.imem_rsp_data  = 32'd0; fbus.if_ready = 1'b0;
    p_ready = 100; p_ifready = 100; lat_min = 1; lat_max = 1;

    // streaming from reset
    do_reset();
    repeat (30) do_cycle(1'b0, 32'd0);
    check("seq_req0", acc_at(0), 32'h0000_3000);
    check("seq_req1", acc_at(1), 32'h0000_3004);
    check("seq_req2", acc_at(2), 32'h0000_3008);
    check("seq_del0", del_at(0), 32'h0000_3000);
    check("seq_del1", del_at(1), 32'h0000_3004);

    // decode stall fills the queue, then drains in order
    do_reset();
    p_ifready = 0;
    repeat (10) do_cycle(1'b0, 32'd0);
    check("stall_accepts", acc_log.size(), 32'd2);
    p_ifready = 100;
    repeat (12) do_cycle(1'b0, 32'd0);
    check("stall_del0", del_at(0), 32'h0000_3000);
    check("stall_del1", del_at(1), 32'h0000_3004);
    check("stall_del2", del_at(2), 32'h0000_3008);

    // redirect with two stale fetches in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq.size() < 2; i++) do_cycle(1'b0, 32'd0);
    check("two_inflight", mq.size(), 32'd2);
    do_cycle(1'b1, 32'h0000_4000);
    base = del_log.size();
    repeat (15) do_cycle(1'b0, 32'd0);
    check("redir_first_pc", del_at(base), 32'h0000_4000);

    // redirect coinciding with a response and a decode pop
    do_reset();
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && dq.size() > 0) begin
        found = 1'b1;
        do_cycle(1'b1, 32'h0000_5000);
      end else begin
        do_cycle(1'b0, 32'd0);
      end
    end
    check("coincide_found", found, 32'd1);
    n = acc_log.size();
    do_cycle(1'b0, 32'd0);
    check("coincide_req", acc_at(n), 32'h0000_5000);
    repeat (6) do_cycle(1'b0, 32'd0);

    // misaligned redirect: sticky error, queue drains, reset recovers
    do_reset();
    p_ifready = 0;
    repeat (6) do_cycle(1'b0, 32'd0);
    p_ifready = 100;
    n = acc_log.size();
    do_cycle(1'b1, 32'h0000_4002);
    repeat (10) do_cycle(1'b1, 32'h0000_6000);
    check("err_held", fbus.fetch_err, 32'd1);
    check("err_no_req", acc_log.size(), n);
    check("err_drained", del_log.size(), 32'd2);
    do_reset();
    repeat (6) do_cycle(1'b0, 32'd0);
    check("recover_del0", del_at(0), 32'h0000_3000);

    // PC wrap at the top of the address space
    do_reset();
    repeat (2) do_cycle(1'b0, 32'd0);
    do_cycle(1'b1, 32'hFFFF_FFFC);
    n = acc_log.size();
    repeat (8) do_cycle(1'b0, 32'd0);
    check("wrap_req0", acc_at(n), 32'hFFFF_FFFC);
    check("wrap_req1", acc_at(n + 1), 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 0) begin
        p_ready   = $urandom_range(100, 30);
        p_ifready = $urandom_range(100, 20);
        lat_min   = 1;
        lat_max   = $urandom_range(4, 1);
        do_reset();
      end
      r = $urandom_range(63);
      if (r < 4) do_cycle(1'b1, $urandom & 32'hFFFF_FFFC);
      else if (r == 4 && (i % 150) > 100) do_cycle(1'b1, ($urandom & 32'hFFFF_FFFC) | 32'd1);
      else do_cycle(1'b0, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
